rx_pkt_arb: RTL and testbench

RX_PKT_ARB -- requirements
Module: rxpktarb

---
 rtl/rx_pkt_arb.sv | 187 ++++++++++++++++++
 tb/tb_rx_pkt_arb.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_arb.sv
// rx_pkt_arb: round-robin merge of NIN byte packet streams into one
// registered stream. Define RXPKTARB_STATS_EN for o_drops counters.
module rx_pkt_arb #(
  parameter int NIN = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NIN-1:0]   S_AXIN_VALID,
  input  logic [NIN-1:0]   S_AXIN_LAST,
  input  logic [NIN-1:0]   S_AXIN_ABORT,
  input  logic [8*NIN-1:0] S_AXIN_DATA,
  output logic [NIN-1:0]   S_AXIN_READY,
  output logic             M_AXIN_VALID,
  output logic [7:0]       M_AXIN_DATA,
  output logic             M_AXIN_LAST,
  output logic             M_AXIN_ABORT,
  input  logic             M_AXIN_READY,
`ifdef RXPKTARB_STATS_EN
  output logic [1:0]       o_grant,
  output logic [16*NIN-1:0] o_drops
`else
  output logic [1:0]       o_grant
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    ABORT
  } state_t;

  state_t         state;
  logic [NIN-1:0] midpkt;
  logic [NIN-1:0] elig;
  logic [NIN-1:0] gsel;
  logic [NIN-1:0] fwd;
  logic [NIN-1:0] owned;
  logic [NIN-1:0] rdy;
  logic [NIN-1:0] sink;
  logic [1:0]     win;
  logic           win_vld;
  logic           out_free;
  logic           g_valid;
  logic           g_last;
  logic           g_abort;
  logic [7:0]     g_data;
  logic           acc;

  assign elig     = S_AXIN_VALID & ~midpkt
                  & ~S_AXIN_ABORT;
  assign out_free = !M_AXIN_VALID
                  || M_AXIN_READY;

  // round-robin pick, searching from the slot after o_grant
  always_comb begin : rr_pick
    int idx;
    win     = o_grant;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NIN; i++) begin
      idx = (int'(o_grant) + i) % NIN;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = 2'(idx);
      end
    end
  end

  // granted-source select and per-source ready / sink
  always_comb begin
    gsel    = '0;
    fwd     = '0;
    owned   = '0;
    rdy     = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_abort = 1'b0;
    g_data  = 8'h00;
    for (int k = 0; k < NIN; k++) begin
      gsel[k] = (o_grant == 2'(k));
      if (gsel[k]) begin
        g_valid = S_AXIN_VALID[k];
        g_last  = S_AXIN_LAST[k];
        g_abort = S_AXIN_ABORT[k];
        g_data  = S_AXIN_DATA[8*k +: 8];
      end
      fwd[k]   = (state == PASS) && gsel[k];
      owned[k] = (state != IDLE) && gsel[k];
      unique case (state)
        IDLE:
          rdy[k] = !(win_vld
                   && (win == 2'(k)));
        PASS:
          rdy[k] = gsel[k] ? out_free : 1'b1;
        default:
          rdy[k] = 1'b1;
      endcase
    end
  end

  assign sink = S_AXIN_VALID & rdy & ~fwd;
  assign acc  = (state == PASS) && g_valid
             && out_free && !g_abort;

  assign S_AXIN_READY = i_reset ? '0 : rdy;

  // arbiter FSM with registered output stage
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      o_grant      <= 2'd0;
      midpkt       <= '0;
      M_AXIN_VALID <= 1'b0;
      M_AXIN_DATA  <= 8'h00;
      M_AXIN_LAST  <= 1'b0;
      M_AXIN_ABORT <= 1'b0;
    end else begin
      for (int k = 0; k < NIN; k++) begin
        if (S_AXIN_ABORT[k])
          midpkt[k] <= 1'b0;
        else if (sink[k])
          midpkt[k] <= !S_AXIN_LAST[k];
      end
      unique case (state)
        IDLE: begin
          if (M_AXIN_READY) begin
            M_AXIN_VALID <= 1'b0;
            M_AXIN_LAST  <= 1'b0;
          end
          if (win_vld) begin
            o_grant <= win;
            state   <= PASS;
          end
        end
        PASS: begin
          if (g_abort) begin
            state        <= ABORT;
            M_AXIN_VALID <= 1'b0;
            M_AXIN_LAST  <= 1'b0;
            M_AXIN_ABORT <= 1'b1;
          end else if (acc) begin
            M_AXIN_VALID <= 1'b1;
            M_AXIN_DATA  <= g_data;
            M_AXIN_LAST  <= g_last;
            if (g_last)
              state <= IDLE;
          end else if (M_AXIN_READY) begin
            M_AXIN_VALID <= 1'b0;
            M_AXIN_LAST  <= 1'b0;
          end
        end
        ABORT: begin
          M_AXIN_VALID <= 1'b0;
          M_AXIN_LAST  <= 1'b0;
          if (!g_valid && !g_abort) begin
            state        <= IDLE;
            M_AXIN_ABORT <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RXPKTARB_STATS_EN
  logic [NIN-1:0] drop_evt;

  assign drop_evt = ~owned & (
      (sink & (S_AXIN_LAST | S_AXIN_ABORT))
    | (S_AXIN_ABORT & midpkt));

  // saturating per-source dropped-packet counters
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_drops <= '0;
    end else begin
      for (int k = 0; k < NIN; k++) begin
        if (drop_evt[k]
            && (o_drops[16*k +: 16] != 16'hFFFF))
          o_drops[16*k +: 16] <=
            o_drops[16*k +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_pkt_arb.sv
// tb_rx_pkt_arb: scoreboard bench for rx_pkt_arb, NIN=2.
// Stats checks compile in with RXPKTARB_STATS_EN.
module tb_rx_pkt_arb;
  localparam int NIN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sv[2];
  logic       sl[2];
  logic       sa[2];
  logic [7:0] sd[2];
  logic       mr;

  logic [NIN-1:0]   s_valid;
  logic [NIN-1:0]   s_last;
  logic [NIN-1:0]   s_abort;
  logic [8*NIN-1:0] s_data;
  logic [NIN-1:0]   s_ready;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_last;
  logic             m_abort;
  logic [1:0]       grant;
`ifdef RXPKTARB_STATS_EN
  logic [16*NIN-1:0] drops;
`endif

  assign s_valid = {sv[1], sv[0]};
  assign s_last  = {sl[1], sl[0]};
  assign s_abort = {sa[1], sa[0]};
  assign s_data  = {sd[1], sd[0]};

  rx_pkt_arb #(.NIN(NIN)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .S_AXIN_VALID (s_valid),
    .S_AXIN_LAST  (s_last),
    .S_AXIN_ABORT (s_abort),
    .S_AXIN_DATA  (s_data),
    .S_AXIN_READY (s_ready),
    .M_AXIN_VALID (m_valid),
    .M_AXIN_DATA  (m_data),
    .M_AXIN_LAST  (m_last),
    .M_AXIN_ABORT (m_abort),
    .M_AXIN_READY (mr),
`ifdef RXPKTARB_STATS_EN
    .o_grant      (grant),
    .o_drops      (drops)
`else
    .o_grant      (grant)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t q[$];
  int    errs = 0;
  int    checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  function automatic void expect_beat(
      input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q.push_back(b);
  endfunction

  task automatic put(input int k,
                     input logic [7:0] d,
                     input logic l);
    int n;
    n = 0;
    sv[k] = 1'b1;
    sd[k] = d;
    sl[k] = l;
    #1;
    while (!s_ready[k] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100)
      check("put_timeout", 1, 0);
    @(negedge clk);
    sv[k] = 1'b0;
    sl[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && m_valid && mr) begin
      if (q.size() == 0) begin
        check("extra_beat", {24'h0, m_data},
              32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = q.pop_front();
        check("out_data", {24'h0, m_data},
              {24'h0, b.d});
        check("out_last", {31'h0, m_last},
              {31'h0, b.l});
        check("out_noabort", {31'h0, m_abort},
              32'h0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mr  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0;
      sl[k] = 1'b0;
      sa[k] = 1'b0;
      sd[k] = 8'h00;
    end
    #12;
    check("rst_mvalid", {31'h0, m_valid}, 0);
    check("rst_mdata", {24'h0, m_data}, 0);
    check("rst_mlast", {31'h0, m_last}, 0);
    check("rst_mabort", {31'h0, m_abort}, 0);
    check("rst_ready", {30'h0, s_ready}, 0);
    check("rst_grant", {30'h0, grant}, 0);
`ifdef RXPKTARB_STATS_EN
    check("rst_drops", drops, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single source, four bytes
    expect_beat(8'h11, 1'b0);
    expect_beat(8'h12, 1'b0);
    expect_beat(8'h13, 1'b0);
    expect_beat(8'h14, 1'b1);
    put(0, 8'h11, 1'b0);
    #1;
    check("lat_valid", {31'h0, m_valid}, 1);
    check("lat_data", {24'h0, m_data}, 32'h11);
    put(0, 8'h12, 1'b0);
    put(0, 8'h13, 1'b0);
    put(0, 8'h14, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("s1_grant", {30'h0, grant}, 0);
    check("s1_empty", q.size(), 0);

    // simultaneous start: source 1 wins
    expect_beat(8'h21, 1'b0);
    expect_beat(8'h22, 1'b0);
    expect_beat(8'h23, 1'b1);
    fork
      begin
        put(1, 8'h21, 1'b0);
        put(1, 8'h22, 1'b0);
        put(1, 8'h23, 1'b1);
      end
      begin
        put(0, 8'h31, 1'b0);
        put(0, 8'h32, 1'b0);
        put(0, 8'h33, 1'b1);
      end
    join
    repeat (2) @(negedge clk);
    #1;
    check("s2_grant", {30'h0, grant}, 1);
    check("s2_empty", q.size(), 0);
`ifdef RXPKTARB_STATS_EN
    check("s2_drops", {16'h0, drops[15:0]}, 1);
`endif

    // abort after two beats
    expect_beat(8'h41, 1'b0);
    expect_beat(8'h42, 1'b0);
    put(1, 8'h41, 1'b0);
    put(1, 8'h42, 1'b0);
    sv[1] = 1'b1;
    sd[1] = 8'h43;
    sa[1] = 1'b1;
    @(negedge clk);
    #1;
    check("abt_flag", {31'h0, m_abort}, 1);
    check("abt_valid", {31'h0, m_valid}, 0);
    @(negedge clk);
    #1;
    check("abt_hold", {31'h0, m_abort}, 1);
    check("abt_hold_v", {31'h0, m_valid}, 0);
    sv[1] = 1'b0;
    sa[1] = 1'b0;
    @(negedge clk);
    #1;
    check("abt_clear", {31'h0, m_abort}, 0);
    check("s3_empty", q.size(), 0);

    // source 0 starts mid-grant of source 1
    expect_beat(8'h51, 1'b0);
    expect_beat(8'h52, 1'b0);
    expect_beat(8'h53, 1'b0);
    expect_beat(8'h54, 1'b1);
    fork
      begin
        put(1, 8'h51, 1'b0);
        put(1, 8'h52, 1'b0);
        put(1, 8'h53, 1'b0);
        put(1, 8'h54, 1'b1);
      end
      begin
        @(negedge clk);
        put(0, 8'h61, 1'b0);
        put(0, 8'h62, 1'b0);
        put(0, 8'h63, 1'b0);
        put(0, 8'h64, 1'b0);
        put(0, 8'h65, 1'b0);
        put(0, 8'h66, 1'b1);
      end
    join
    expect_beat(8'h71, 1'b0);
    expect_beat(8'h72, 1'b1);
    put(0, 8'h71, 1'b0);
    put(0, 8'h72, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("s4_grant", {30'h0, grant}, 0);
    check("s4_empty", q.size(), 0);
`ifdef RXPKTARB_STATS_EN
    check("s4_drops", {16'h0, drops[15:0]}, 2);
`endif

    // backpressure on granted source
    expect_beat(8'h81, 1'b0);
    expect_beat(8'h82, 1'b1);
    mr = 1'b0;
    put(1, 8'h81, 1'b0);
    sv[1] = 1'b1;
    sd[1] = 8'h82;
    sl[1] = 1'b1;
    #1;
    check("bp_ready", {31'h0, s_ready[1]}, 0);
    check("bp_valid", {31'h0, m_valid}, 1);
    check("bp_data", {24'h0, m_data}, 32'h81);
    mr = 1'b1;
    put(1, 8'h82, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("s5_empty", q.size(), 0);

    // reset during beat 3 of a 6-beat packet
    expect_beat(8'h91, 1'b0);
    put(0, 8'h91, 1'b0);
    put(0, 8'h92, 1'b0);
    sv[0] = 1'b1;
    sd[0] = 8'h93;
    #1;
    rst = 1'b1;
    #1;
    check("arst_mvalid", {31'h0, m_valid}, 0);
    check("arst_mdata", {24'h0, m_data}, 0);
    check("arst_ready", {30'h0, s_ready}, 0);
    check("arst_grant", {30'h0, grant}, 0);
`ifdef RXPKTARB_STATS_EN
    check("arst_drops", drops, 0);
`endif
    sv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_beat(8'hA1, 1'b0);
    expect_beat(8'hA2, 1'b1);
    put(0, 8'hA1, 1'b0);
    put(0, 8'hA2, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("s6_empty", q.size(), 0);
    check("s6_grant", {30'h0, grant}, 0);

`ifdef RXPKTARB_STATS_EN
    // drop counter saturation
    expect_beat(8'hB1, 1'b0);
    put(1, 8'hB1, 1'b0);
    sv[0] = 1'b1;
    sl[0] = 1'b1;
    sd[0] = 8'hC0;
    repeat (65534) @(negedge clk);
    #1;
    check("sat_pre", {16'h0, drops[15:0]},
          32'hFFFE);
    repeat (3) @(negedge clk);
    #1;
    check("sat_max", {16'h0, drops[15:0]},
          32'hFFFF);
    sv[0] = 1'b0;
    sl[0] = 1'b0;
    expect_beat(8'hB2, 1'b1);
    put(1, 8'hB2, 1'b1);
`endif

    repeat (3) @(negedge clk);
    #1;
    check("end_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
